// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the instruction/data memory port arbiter.
// State encoding is kept as plain 2-bit constants so older blocks can match on it.
package mem_port_arbiter_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_IF_XFER = 2'd1;
  localparam logic [1:0] ST_D_XFER  = 2'd2;
  localparam logic [1:0] ST_TURN    = 2'd3;

  localparam logic [3:0] BE_WORD = 4'hF;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and data ports onto one memory interface, one transfer at a time.
// Define MEM_ARB_RR_EN for round-robin tie breaking; otherwise data always wins a tie.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        mem_busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  logic [1:0]  state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic        if_valid_q, if_valid_d;
  logic        d_valid_q, d_valid_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        flush_q, flush_d;
  logic        grant_data;
`ifdef MEM_ARB_RR_EN
  logic        last_grant_q, last_grant_d;
`endif

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    flush_d     = flush_q;
`ifdef MEM_ARB_RR_EN
    last_grant_d = last_grant_q;
    // On a tie, data only wins if fetch was the previous grant.
    grant_data   = d_req && (!if_req || !last_grant_q);
`else
    grant_data   = d_req;
`endif

    case (state_q)
      ST_IDLE: begin
        if (grant_data) begin
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_be_d    = d_be;
          state_d     = ST_D_XFER;
`ifdef MEM_ARB_RR_EN
          last_grant_d = 1'b1;
`endif
        end else if (if_req) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
          mem_be_d   = BE_WORD;
          state_d    = ST_IF_XFER;
`ifdef MEM_ARB_RR_EN
          last_grant_d = 1'b0;
`endif
        end
      end
      ST_IF_XFER: begin
        // A redirect seen on the ack cycle itself must still suppress the pulse.
        flush_d = flush_q | if_flush;
        if (mem_ack) begin
          mem_req_d  = 1'b0;
          if_rdata_d = mem_rdata;
          if_valid_d = ~(flush_q | if_flush);
          flush_d    = 1'b0;
          state_d    = ST_TURN;
        end
      end
      ST_D_XFER: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (!mem_we_q) d_rdata_d = mem_rdata;
          d_valid_d = 1'b1;
          state_d   = ST_TURN;
        end
      end
      ST_TURN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_be_q    <= 4'd0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      if_rdata_q  <= 32'd0;
      d_rdata_q   <= 32'd0;
      flush_q     <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      flush_q     <= flush_d;
`ifdef MEM_ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // A pending data request in IDLE already counts as busy so the pipeline can stall early.
  assign mem_busy  = (state_q != ST_IDLE) || d_req;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter; honours MEM_ARB_RR_EN when defined.
// A transaction-level reference model is compared against the DUT every cycle.
module tb_mem_port_arbiter;

  logic        clk, rst;
  logic        if_req, if_flush, d_req, d_we, mem_ack;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_be;
  logic        if_valid, d_valid, mem_busy, mem_req, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  int checks = 0;
  int fails = 0;
  int cycle = 0;
  int if_valid_cnt = 0;
  int d_valid_cnt = 0;
  int if_valid_cycles[$];
  logic [31:0] grant_log[$];
  int ack_lat = 1;
  int stray_req = 0;
  int stray_done = 0;
  int if_hold_left = 0;
  bit check_en = 0;

  // Reference model state: owner 0 = nobody, 1 = fetch, 2 = data.
  int          m_owner = 0;
  bit          m_turn = 0;
  bit          m_flush = 0;
  bit          m_last_data = 0;
  logic        e_req = 0, e_we = 0, e_ifv = 0, e_dv = 0;
  logic [31:0] e_addr = 0, e_wdata = 0, e_ifr = 0, e_dr = 0;
  logic [3:0]  e_be = 0;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_busy(mem_busy), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0] ^ 16'hC0DE, a[15:0]};
  endfunction

  function automatic logic [31:0] grant_at(input int i);
    if (i < grant_log.size()) return grant_log[i];
    return 32'hFFFF_FFFF;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Memory responder: acks ack_lat cycles after a request appears, or injects a stray ack.
  initial begin : responder
    int cnt;
    bit given;
    cnt = 0;
    given = 0;
    mem_ack = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (!mem_req) begin
        cnt = 0;
        given = 0;
      end
      if (stray_req != stray_done) begin
        mem_ack = 1'b1;
        mem_rdata = 32'hBAD0BAD0;
        stray_done = stray_req;
      end else if (mem_req && !given) begin
        cnt++;
        if (cnt >= ack_lat) begin
          mem_ack = 1'b1;
          mem_rdata = mem_word(mem_addr);
          given = 1;
        end
      end
    end
  end

  // Reference model, advanced on each clock edge from the bench-driven inputs only.
  initial begin : model
    bit fetch_turn;
    bit data_wins;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_owner = 0; m_turn = 0; m_flush = 0; m_last_data = 0;
        e_req = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_be = 0;
        e_ifv = 0; e_dv = 0; e_ifr = 0; e_dr = 0;
      end else begin
        e_ifv = 0;
        e_dv = 0;
        if (m_turn) begin
          m_turn = 0;
        end else if (m_owner == 1) begin
          if (if_flush) m_flush = 1;
          if (mem_ack) begin
            e_req = 0; e_ifr = mem_rdata; e_ifv = !m_flush;
            m_flush = 0; m_owner = 0; m_turn = 1;
          end
        end else if (m_owner == 2) begin
          if (mem_ack) begin
            e_req = 0;
            if (!e_we) e_dr = mem_rdata;
            e_dv = 1; m_owner = 0; m_turn = 1;
          end
        end else begin
`ifdef MEM_ARB_RR_EN
          fetch_turn = m_last_data;
`else
          fetch_turn = 1'b0;
`endif
          data_wins = d_req && !(if_req && fetch_turn);
          if (data_wins) begin
            e_req = 1; e_we = d_we; e_addr = d_addr; e_wdata = d_wdata; e_be = d_be;
            m_owner = 2; m_last_data = 1;
          end else if (if_req) begin
            e_req = 1; e_we = 0; e_addr = if_addr; e_be = 4'hF;
            m_owner = 1; m_last_data = 0;
          end
        end
      end
    end
  end

  // Compare process: every output against the model, mid-cycle.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (check_en) begin
        check_output("mem_req", 32'(mem_req), 32'(e_req));
        check_output("mem_we", 32'(mem_we), 32'(e_we));
        check_output("mem_addr", mem_addr, e_addr);
        check_output("mem_wdata", mem_wdata, e_wdata);
        check_output("mem_be", 32'(mem_be), 32'(e_be));
        check_output("if_valid", 32'(if_valid), 32'(e_ifv));
        check_output("d_valid", 32'(d_valid), 32'(e_dv));
        check_output("if_rdata", if_rdata, e_ifr);
        check_output("d_rdata", d_rdata, e_dr);
        check_output("mem_busy", 32'(mem_busy), 32'(m_owner != 0 || m_turn || d_req));
      end
    end
  end

  initial begin : monitor
    bit prev_req;
    prev_req = 0;
    forever begin
      @(negedge clk);
      cycle++;
      if (rst) begin
        if (if_valid) begin
          if_valid_cnt++;
          if_valid_cycles.push_back(cycle);
        end
        if (d_valid) d_valid_cnt++;
        if (mem_req && !prev_req) grant_log.push_back(mem_addr);
      end
      prev_req = mem_req;
    end
  end

  // Requesters drop their request after the matching valid pulse, bounded by budget cycles.
  task automatic serve(input int budget);
    int n;
    bit drop_d, drop_if;
    n = 0;
    while ((d_req || if_req) && n < budget) begin
      @(negedge clk);
      n++;
      drop_d = d_valid;
      drop_if = 1'b0;
      if (if_valid) begin
        if (if_hold_left > 0) if_hold_left--;
        else drop_if = 1'b1;
      end
      @(posedge clk);
      #2;
      if (drop_d) d_req = 1'b0;
      if (drop_if) if_req = 1'b0;
    end
    check_output("serve_complete", 32'(d_req || if_req), 32'd0);
    repeat (2) @(posedge clk);
    #2;
  endtask

  initial begin : main
    int base, dv0, iv0, n0;
    rst = 1'b0; if_req = 1'b0; if_addr = 32'd0; if_flush = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0; d_be = 4'd0;

    @(posedge clk);
    #1;
    check_en = 1;
    check_output("reset_mem_req", 32'(mem_req), 32'd0);
    check_output("reset_mem_be", 32'(mem_be), 32'd0);
    check_output("reset_if_rdata", if_rdata, 32'd0);
    check_output("reset_d_rdata", d_rdata, 32'd0);
    check_output("reset_mem_busy", 32'(mem_busy), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b1;

    $display("[TB] tie: data 0x200 vs fetch 0x40");
    @(posedge clk);
    #2;
    if_req = 1'b1; if_addr = 32'h40;
    d_req = 1'b1; d_addr = 32'h200; d_we = 1'b0; d_be = 4'hF;
    base = grant_log.size();
    serve(40);
    check_output("tie_first_grant", grant_at(base), 32'h200);
    check_output("tie_second_grant", grant_at(base + 1), 32'h40);
    check_output("tie_if_rdata", if_rdata, 32'hC09E0040);
    check_output("tie_d_rdata", d_rdata, 32'hC2DE0200);

    $display("[TB] load from 0x100 with two-cycle ack");
    ack_lat = 2;
    d_req = 1'b1; d_addr = 32'h100; d_we = 1'b0;
    dv0 = d_valid_cnt;
    #1;
    check_output("load_busy_on_request", 32'(mem_busy), 32'd1);
    serve(40);
    check_output("load_d_rdata", d_rdata, 32'hDEADBEEF);
    check_output("load_d_valid_count", 32'(d_valid_cnt - dv0), 32'd1);
    check_output("load_busy_after", 32'(mem_busy), 32'd0);

    $display("[TB] store with partial byte enables");
    ack_lat = 3;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_wdata = 32'h1234ABCD; d_addr = 32'h300;
    dv0 = d_valid_cnt;
    @(posedge clk);
    @(negedge clk);
    check_output("store_mem_we", 32'(mem_we), 32'd1);
    check_output("store_mem_be", 32'(mem_be), 32'h3);
    check_output("store_mem_wdata", mem_wdata, 32'h1234ABCD);
    d_addr = 32'h3FC; d_wdata = 32'h0;
    serve(40);
    check_output("store_d_rdata_kept", d_rdata, 32'hDEADBEEF);
    check_output("store_d_valid_count", 32'(d_valid_cnt - dv0), 32'd1);
    check_output("store_addr_held", mem_addr, 32'h300);
    ack_lat = 1;
    d_we = 1'b0; d_be = 4'hF;

    $display("[TB] repeated tie after a data grant");
    if_req = 1'b1; if_addr = 32'h44;
    d_req = 1'b1; d_addr = 32'h204;
    base = grant_log.size();
    serve(40);
`ifdef MEM_ARB_RR_EN
    check_output("tie2_first_grant", grant_at(base), 32'h44);
`else
    check_output("tie2_first_grant", grant_at(base), 32'h204);
`endif

    $display("[TB] flush on the ack cycle of fetch 0x80");
    iv0 = if_valid_cnt;
    base = grant_log.size();
    if_req = 1'b1; if_addr = 32'h80;
    @(posedge clk);
    #2;
    if_flush = 1'b1; if_addr = 32'h90;
    @(posedge clk);
    #2;
    if_flush = 1'b0;
    @(negedge clk);
    check_output("flush_no_if_valid", 32'(if_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_output("flush_idle_after_turn", 32'(mem_busy), 32'd0);
    serve(40);
    check_output("flush_valid_count", 32'(if_valid_cnt - iv0), 32'd1);
    check_output("flush_first_grant", grant_at(base), 32'h80);
    check_output("flush_refetch_grant", grant_at(base + 1), 32'h90);
    check_output("flush_refetch_rdata", if_rdata, 32'hC04E0090);

    $display("[TB] three back-to-back fetches");
    n0 = if_valid_cycles.size();
    if_req = 1'b1; if_addr = 32'h500; if_hold_left = 2;
    serve(60);
    check_output("b2b_valid_count", 32'(if_valid_cycles.size() - n0), 32'd3);
    if (if_valid_cycles.size() >= n0 + 3) begin
      check_output("b2b_spacing_1", 32'(if_valid_cycles[n0 + 1] - if_valid_cycles[n0]), 32'd3);
      check_output("b2b_spacing_2", 32'(if_valid_cycles[n0 + 2] - if_valid_cycles[n0 + 1]), 32'd3);
    end

    $display("[TB] reset during a data transfer");
    ack_lat = 10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
    @(posedge clk);
    @(negedge clk);
    check_output("abort_req_before", 32'(mem_req), 32'd1);
    dv0 = d_valid_cnt;
    iv0 = if_valid_cnt;
    #1;
    rst = 1'b0;
    d_req = 1'b0;
    #1;
    check_output("abort_mem_req", 32'(mem_req), 32'd0);
    check_output("abort_mem_we", 32'(mem_we), 32'd0);
    check_output("abort_mem_addr", mem_addr, 32'd0);
    check_output("abort_mem_wdata", mem_wdata, 32'd0);
    check_output("abort_mem_be", 32'(mem_be), 32'd0);
    check_output("abort_d_rdata", d_rdata, 32'd0);
    check_output("abort_if_rdata", if_rdata, 32'd0);
    check_output("abort_d_valid", 32'(d_valid), 32'd0);
    check_output("abort_mem_busy", 32'(mem_busy), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    stray_req++;
    repeat (4) @(posedge clk);
    #2;
    check_output("stray_no_d_valid", 32'(d_valid_cnt - dv0), 32'd0);
    check_output("stray_no_if_valid", 32'(if_valid_cnt - iv0), 32'd0);
    check_output("stray_mem_req", 32'(mem_req), 32'd0);
    check_output("stray_d_rdata", d_rdata, 32'd0);
    ack_lat = 1;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have these ports, clock and reset first:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held until if_valid
- if_addr  in  32  fetch word address
- if_flush  in  1  pipeline redirect (taken branch or jump); discards the in-flight fetch
- if_valid  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  32  fetched instruction
- d_req  in  1  data request; held until d_valid
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_be  in  4  byte enables
- d_valid  out  1  one-cycle pulse; load data valid or store done
- d_rdata  out  32  load data
- mem_busy  out  1  to pipeline_ctrl; high while the port is not idle
- mem_req  out  1  memory request; held until mem_ack
- mem_we  out  1  memory write strobe
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_be  out  4  memory byte enables
- mem_ack  in  1  one-cycle completion from memory
- mem_rdata  in  32  read data; valid with mem_ack

Function
REQ-002 SHALL implement FSM states IDLE, IF_XFER, D_XFER and TURN.
REQ-003 In IDLE with d_req=1, SHALL latch d_we, d_addr, d_wdata and d_be onto the mem_* outputs, assert mem_req and enter D_XFER on the next edge.
REQ-004 In IDLE with only if_req=1, SHALL latch if_addr, drive mem_we=0 and mem_be=4'hF, assert mem_req and enter IF_XFER.
REQ-005 When d_req and if_req are both high, data SHALL win by default (fixed priority; see REQ-014).
REQ-006 SHALL hold the mem_* outputs stable while mem_req=1; requester input changes after latching SHALL be ignored.
REQ-007 On mem_ack in D_XFER: SHALL deassert mem_req, register d_rdata from mem_rdata (loads only; stores leave it unchanged), pulse d_valid for exactly one cycle, then enter TURN.
REQ-008 On mem_ack in IF_XFER: SHALL deassert mem_req and register if_rdata; SHALL pulse if_valid unless a flush is pending; SHALL then enter TURN.
REQ-009 Flush: if_flush high in any IF_XFER cycle, including the mem_ack cycle, SHALL set a pending flag. The fetch SHALL still complete on the memory side with if_valid suppressed. The flag SHALL clear on leaving IF_XFER.
REQ-010 if_flush in IDLE, D_XFER or TURN SHALL have no effect.
REQ-011 TURN SHALL last exactly one cycle, then return to IDLE. This bounds a request to at least 3 cycles: latch, ack, turn.
REQ-012 mem_busy SHALL equal (state != IDLE) OR (state == IDLE AND d_req), combinationally from the registered state.
REQ-013 mem_ack received outside IF_XFER or D_XFER SHALL be ignored.

Configuration
REQ-014 Macro MEM_ARB_RR_EN:
- Defined: round-robin on simultaneous requests, using a 1-bit last-grant register (0 = fetch, 1 = data). The requester not granted last SHALL win. The register SHALL update on each grant and reset to 0, so data wins the first tie.
- Undefined: fixed data priority per REQ-005, and no last-grant register is built.

Reset
REQ-015 While rst=0, asynchronously:
- state = IDLE
- mem_req, mem_we, if_valid, d_valid, flush flag = 0
- mem_addr, mem_wdata, if_rdata, d_rdata = 0
- mem_be = 0
REQ-016 Reset during a transfer SHALL abandon it; no valid pulse SHALL be issued for it.
REQ-017 After rst rises, the first grant SHALL occur on the first clk edge that sees a request.

Structure
REQ-018 Shared package SHALL hold the state encoding (2 bits: IDLE=0, IF_XFER=1, D_XFER=2, TURN=3) and the constant BE_WORD=4'hF.
REQ-019 No sub-module; single always block for the FSM and datapath registers, plus the mem_busy assign.

Verification
REQ-020 Bench SHALL cover:
- Load: d_req=1, d_we=0, d_addr=0x100, mem_ack 2 cycles after mem_req with mem_rdata=0xDEADBEEF -> d_valid one cycle, d_rdata=0xDEADBEEF, mem_busy high from request until TURN ends.
- Tie: if_req and d_req rise together, if_addr=0x40, d_addr=0x200 -> first mem_addr=0x200, second mem_addr=0x40. With MEM_ARB_RR_EN, a repeated tie grants fetch first.
- Flush: fetch at 0x80, if_flush pulsed in the mem_ack cycle -> no if_valid, state reaches IDLE after TURN, next fetch at 0x90 returns normally.
- Store: d_we=1, d_be=4'b0011, d_wdata=0x1234ABCD -> mem_we=1, mem_be=0x3, d_valid pulses, d_rdata unchanged.
- Reset mid-transfer: rst low during D_XFER -> all outputs 0 immediately, no d_valid; a later stray mem_ack is ignored.
- Back-to-back: if_req held high across 3 fetches with single-cycle ack -> exactly 3 if_valid pulses, spaced 3 cycles apart.
